udp_payload_fifo: RTL



---
 rtl/udp_payload_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/udp_payload_fifo.sv
// Frame-aware payload byte FIFO between the UDP parser and application logic.
// Frames are committed on their last byte; frames that do not fit are dropped whole.
module udp_payload_fifo #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  payload,
  input  logic        payload_valid,
  input  logic        payload_last,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_dropped,
  output logic [15:0] drop_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_commit_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_dropped;
  logic [15:0]       r_drop_cnt;
  logic [8:0]        r_mem [DEPTH];
  logic [8:0]        r_s1_word;
  logic              r_s1_valid;
  logic [8:0]        r_out_word;
  logic              r_out_valid;

  logic [ADDR_W:0]   w_level;
  logic              w_full;
  logic              w_wr_en;
  logic              w_out_take;
  logic              w_s1_move;
  logic              w_rd_en;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == FULL_LVL);
  assign w_wr_en = payload_valid && !w_full &&
                   (r_state != S_DROP);

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[ADDR_W-1:0]] <=
        {payload_last, payload};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_dropped    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_dropped <= 1'b0;
      unique case (r_state)
        S_IDLE, S_RECV: begin
          if (payload_valid) begin
            if (w_full) begin
              if (payload_last) begin
                r_wr_ptr  <= r_commit_ptr;
                r_dropped <= 1'b1;
                if (r_drop_cnt != 16'hFFFF)
                  r_drop_cnt <= r_drop_cnt + 16'd1;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_DROP;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (payload_last) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_state <= S_RECV;
              end
            end
          end
        end
        S_DROP: begin
          if (payload_valid && payload_last) begin
            r_wr_ptr  <= r_commit_ptr;
            r_dropped <= 1'b1;
            if (r_drop_cnt != 16'hFFFF)
              r_drop_cnt <= r_drop_cnt + 16'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-stage show-ahead read: RAM output register, then output register.
  assign w_out_take = !r_out_valid || out_ready;
  assign w_s1_move  = r_s1_valid && w_out_take;
  assign w_rd_en    = (r_rd_ptr != r_commit_ptr) &&
                      (!r_s1_valid || w_s1_move);

  always_ff @(posedge clk) begin
    if (w_rd_en)
      r_s1_word <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr    <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
    end else begin
      if (w_rd_en)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_en)
        r_s1_valid <= 1'b1;
      else if (w_s1_move)
        r_s1_valid <= 1'b0;
      if (w_s1_move) begin
        r_out_valid <= 1'b1;
        r_out_word  <= r_s1_word;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data      = r_out_word[7:0];
  assign out_last      = r_out_word[8];
  assign out_valid     = r_out_valid;
  assign frame_dropped = r_dropped;
  assign drop_count    = r_drop_cnt;

endmodule
